// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, segment bit positions and active-low hex patterns (dp off).
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIT  = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  // Positions inside the active-low segment bus: a..g on [7:1], dp on [0].
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_HEX_0 = 8'h03;
  localparam logic [7:0] SEG_HEX_1 = 8'h9F;
  localparam logic [7:0] SEG_HEX_2 = 8'h25;
  localparam logic [7:0] SEG_HEX_3 = 8'h0D;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h49;
  localparam logic [7:0] SEG_HEX_6 = 8'h41;
  localparam logic [7:0] SEG_HEX_7 = 8'h1F;
  localparam logic [7:0] SEG_HEX_8 = 8'h01;
  localparam logic [7:0] SEG_HEX_9 = 8'h09;
  localparam logic [7:0] SEG_HEX_A = 8'h11;
  localparam logic [7:0] SEG_HEX_B = 8'hC1;
  localparam logic [7:0] SEG_HEX_C = 8'h63;
  localparam logic [7:0] SEG_HEX_D = 8'h85;
  localparam logic [7:0] SEG_HEX_E = 8'h61;
  localparam logic [7:0] SEG_HEX_F = 8'h71;
  localparam logic [7:0] SEG_DARK  = 8'hFF;

  function automatic logic [7:0] hex_pattern(input logic [3:0] hex);
    case (hex)
      4'h0: hex_pattern = SEG_HEX_0;
      4'h1: hex_pattern = SEG_HEX_1;
      4'h2: hex_pattern = SEG_HEX_2;
      4'h3: hex_pattern = SEG_HEX_3;
      4'h4: hex_pattern = SEG_HEX_4;
      4'h5: hex_pattern = SEG_HEX_5;
      4'h6: hex_pattern = SEG_HEX_6;
      4'h7: hex_pattern = SEG_HEX_7;
      4'h8: hex_pattern = SEG_HEX_8;
      4'h9: hex_pattern = SEG_HEX_9;
      4'hA: hex_pattern = SEG_HEX_A;
      4'hB: hex_pattern = SEG_HEX_B;
      4'hC: hex_pattern = SEG_HEX_C;
      4'hD: hex_pattern = SEG_HEX_D;
      4'hE: hex_pattern = SEG_HEX_E;
      default: hex_pattern = SEG_HEX_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational {dp, hex} to active-low segment decoder; one instance shared by all digits.
module seg_hex_dec
  import seg_scan_pkg::*;
(
  input  logic [4:0] i_val,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  always_comb begin
    w_pat         = hex_pattern(i_val[3:0]);
    o_seg         = SEG_DARK;
    o_seg[SEG_A]  = w_pat[SEG_A];
    o_seg[SEG_B]  = w_pat[SEG_B];
    o_seg[SEG_C]  = w_pat[SEG_C];
    o_seg[SEG_D]  = w_pat[SEG_D];
    o_seg[SEG_E]  = w_pat[SEG_E];
    o_seg[SEG_F]  = w_pat[SEG_F];
    o_seg[SEG_G]  = w_pat[SEG_G];
    // Table patterns carry dp off; the dp segment lights only when requested.
    o_seg[SEG_DP] = w_pat[SEG_DP] & ~i_val[4];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with shadow/live digit buffers.
// Optional build macro LEADING_ZERO_BLANK_EN keeps digits above the highest nonzero one dark.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYC    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_wr_en,
  input  logic [2:0]            i_wr_idx,
  input  logic [4:0]            i_wr_data,
  input  logic                  i_commit,
  output logic                  o_commit_pend,
  output logic [7:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_dig_sel,
  output logic                  o_frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] LIT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [2:0]    PTR_LAST = 3'(NUM_DIGITS - 1);

  scan_state_t           r_state, w_state_nxt;
  logic [2:0]            r_ptr, w_ptr_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_frame_end;
  logic [4:0]            r_shadow [NUM_DIGITS];
  logic [4:0]            r_live   [NUM_DIGITS];
  logic [4:0]            w_shadow_nxt [NUM_DIGITS];
  logic                  r_commit_pend, w_pend, w_apply;
  logic [4:0]            w_cur_val;
  logic                  w_cur_blank;
  logic [NUM_DIGITS-1:0] w_blank, w_sel_lit;
  logic [7:0]            w_dec_seg, r_seg;
  logic [NUM_DIGITS-1:0] r_dig_sel;
  logic                  r_frame_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_LIT;
        w_ptr_nxt   = '0;
        w_cnt_nxt   = '0;
      end
      ST_LIT: begin
        if (r_cnt == LIT_LAST) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_LIT;
          w_cnt_nxt   = '0;
          if (r_ptr == PTR_LAST) begin
            w_ptr_nxt   = '0;
            w_frame_end = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disable wins over everything, including the frame boundary.
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = '0;
      w_cnt_nxt   = '0;
      w_frame_end = 1'b0;
    end
  end

  // Same-cycle writes are folded in before the shadow is copied to live.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_shadow_nxt[i] = (i_wr_en && (i_wr_idx == 3'(i))) ? i_wr_data : r_shadow[i];
    end
  end

  assign w_pend  = r_commit_pend | i_commit;
  assign w_apply = ((r_state == ST_IDLE) && r_commit_pend) || (w_frame_end && w_pend);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_commit_pend <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      r_commit_pend <= w_pend & ~w_apply;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_apply) r_live[i] <= w_shadow_nxt[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_seen;
  always_comb begin
    w_blank = '0;
    w_seen  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (r_live[i] != 5'd0) w_seen = 1'b1;
      w_blank[i] = ~w_seen;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_cur_val   = '0;
    w_cur_blank = 1'b0;
    w_sel_lit   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_ptr == 3'(i)) begin
        w_cur_val    = r_live[i];
        w_cur_blank  = w_blank[i];
        w_sel_lit[i] = 1'b0;
      end
    end
  end

  seg_hex_dec u_dec (
    .i_val (w_cur_val),
    .o_seg (w_dec_seg)
  );

  // Pins follow the state one cycle later; i_en low darkens them on the very next edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg        <= SEG_DARK;
      r_dig_sel    <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (i_en && (r_state == ST_LIT) && !w_cur_blank) begin
        r_seg     <= w_dec_seg;
        r_dig_sel <= w_sel_lit;
      end else begin
        r_seg     <= SEG_DARK;
        r_dig_sel <= '1;
      end
    end
  end

  assign o_seg         = r_seg;
  assign o_dig_sel     = r_dig_sel;
  assign o_frame_done  = r_frame_done;
  assign o_commit_pend = r_commit_pend;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at NUM_DIGITS=4, SCAN_DIV=4, GAP_CYC=1 (frame = 20 cycles).
// Build with +define+LEADING_ZERO_BLANK_EN to exercise leading-zero blanking.
module tb_seg_scan_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_wr_en, i_commit;
  logic [2:0] i_wr_idx;
  logic [4:0] i_wr_data;
  logic       o_commit_pend, o_frame_done;
  logic [7:0] o_seg;
  logic [3:0] o_dig_sel;

  int n_checks = 0;
  int n_errors = 0;
  logic [12:0] exp_q[$];

  localparam logic [12:0] DARK = {1'b0, 4'hF, 8'hFF};

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .GAP_CYC(1)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_wr_en       (i_wr_en),
    .i_wr_idx      (i_wr_idx),
    .i_wr_data     (i_wr_data),
    .i_commit      (i_commit),
    .o_commit_pend (o_commit_pend),
    .o_seg         (o_seg),
    .o_dig_sel     (o_dig_sel),
    .o_frame_done  (o_frame_done)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_en = 1'b0; i_wr_en = 1'b0; i_commit = 1'b0;
    i_wr_idx = 3'd0; i_wr_data = 5'd0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // driver tasks
  task automatic drive_idle();
    i_wr_en = 1'b0; i_commit = 1'b0;
  endtask

  task automatic drive_wr(input logic [2:0] idx, input logic [4:0] data);
    i_wr_en = 1'b1; i_wr_idx = idx; i_wr_data = data;
  endtask

  // expected-value model, written from the display description
  function automatic logic [7:0] seg_of(input logic [4:0] v);
    logic [7:0] s;
    case (v[3:0])
      4'h0: s = 8'h03; 4'h1: s = 8'h9F; 4'h2: s = 8'h25; 4'h3: s = 8'h0D;
      4'h4: s = 8'h99; 4'h5: s = 8'h49; 4'h6: s = 8'h41; 4'h7: s = 8'h1F;
      4'h8: s = 8'h01; 4'h9: s = 8'h09; 4'hA: s = 8'h11; 4'hB: s = 8'hC1;
      4'hC: s = 8'h63; 4'hD: s = 8'h85; 4'hE: s = 8'h61; default: s = 8'h71;
    endcase
    if (v[4]) s[0] = 1'b0;
    return s;
  endfunction

  // k = clock edges since the edge that first saw i_en=1 (0 = that edge itself).
  // live packs {d3, d2, d1, d0}, 5 bits each. Returns {frame_done, dig_sel, seg}.
  function automatic logic [12:0] exp_pins(input int k, input logic [19:0] live);
    logic [12:0] r;
    logic [3:0]  oh;
    logic        blank;
    int p, d, w;
    r = DARK;
    if (k <= 0) return r;
    p = (k - 1) % 20;
    d = p / 5;
    w = p % 5;
    r[12] = (k % 20 == 0);
    if (w < 4) begin
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0) begin
        blank = 1'b1;
        for (int j = d; j < 4; j++) if (live[j*5 +: 5] != 5'd0) blank = 1'b0;
      end
`endif
      if (!blank) begin
        oh = 4'b0001 << d;
        r[11:8] = ~oh;
        r[7:0]  = seg_of(live[d*5 +: 5]);
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_seg !== 8'hFF) begin n_errors++; $display("FAIL reset_seg got=%h exp=ff", o_seg); end
    n_checks++;
    if (o_dig_sel !== 4'hF) begin n_errors++; $display("FAIL reset_dig_sel got=%h exp=f", o_dig_sel); end
    n_checks++;
    if (o_frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
    n_checks++;
    if (o_commit_pend !== 1'b0) begin n_errors++; $display("FAIL reset_commit_pend got=%b exp=0", o_commit_pend); end
  endtask

  task automatic test_scan();
    logic [12:0] got_v, exp_v;
    int fd_cnt = 0;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      drive_idle();
      i_en = 1'b1;
      exp_q.push_back(exp_pins(k, 20'd0));
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      if (o_frame_done === 1'b1) fd_cnt++;
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL scan k=%0d got=%h exp=%h", k, got_v, exp_v); end
    end
    n_checks++;
    if (fd_cnt !== 2) begin n_errors++; $display("FAIL scan_frame_count got=%0d exp=2", fd_cnt); end
  endtask

  task automatic test_commit();
    logic [12:0] got_v, exp_v;
    logic [19:0] live;
    logic        pend_exp;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      drive_idle();
      i_en = 1'b1;
      case (k)
        6: drive_wr(3'd0, 5'h05);
        7: drive_wr(3'd1, 5'h1A);
        8: i_commit = 1'b1;
        default: ;
      endcase
      live = (k > 20) ? {5'h00, 5'h00, 5'h1A, 5'h05} : 20'd0;
      exp_q.push_back(exp_pins(k, live));
      pend_exp = (k >= 8) && (k < 20);
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL commit k=%0d got=%h exp=%h", k, got_v, exp_v); end
      n_checks++;
      if (o_commit_pend !== pend_exp) begin n_errors++; $display("FAIL commit_pend k=%0d got=%b exp=%b", k, o_commit_pend, pend_exp); end
    end
  endtask

  task automatic test_write_no_commit();
    logic [12:0] got_v, exp_v;
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      drive_idle();
      i_en = 1'b1;
      if (k == 3) drive_wr(3'd2, 5'h08);
      exp_q.push_back(exp_pins(k, 20'd0));
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL nocommit k=%0d got=%h exp=%h", k, got_v, exp_v); end
      n_checks++;
      if (o_commit_pend !== 1'b0) begin n_errors++; $display("FAIL nocommit_pend k=%0d got=%b exp=0", k, o_commit_pend); end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got_v, exp_v;
    logic [19:0] live;
    logic        pend_exp;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      drive_idle();
      i_en = 1'b1;
      if (k == 5) drive_wr(3'd4, 5'h0E);
      if (k == 10) begin
        drive_wr(3'd3, 5'h07);
        i_commit = 1'b1;
      end
      live = (k > 20) ? {5'h07, 5'h00, 5'h00, 5'h00} : 20'd0;
      exp_q.push_back(exp_pins(k, live));
      pend_exp = (k >= 10) && (k < 20);
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL wr_commit k=%0d got=%h exp=%h", k, got_v, exp_v); end
      n_checks++;
      if (o_commit_pend !== pend_exp) begin n_errors++; $display("FAIL wr_commit_pend k=%0d got=%b exp=%b", k, o_commit_pend, pend_exp); end
    end
  endtask

  task automatic test_disable();
    logic [12:0] got_v, exp_v;
    logic [19:0] live;
    live = {5'h04, 5'h03, 5'h02, 5'h01};
    do_reset();
    // Load all digits and commit while idle: applies one cycle after the request.
    for (int j = 0; j <= 5; j++) begin
      drive_idle();
      if (j < 4) drive_wr(3'(j), 5'(j + 1));
      if (j == 4) i_commit = 1'b1;
      tick();
      n_checks++;
      if (o_commit_pend !== (j == 4)) begin n_errors++; $display("FAIL idle_commit_pend j=%0d got=%b exp=%b", j, o_commit_pend, (j == 4)); end
    end
    for (int k = 0; k <= 35; k++) begin
      drive_idle();
      i_en = !((k >= 7) && (k < 10));
      if (k < 7)       exp_q.push_back(exp_pins(k, live));
      else if (k < 10) exp_q.push_back(DARK);
      else             exp_q.push_back(exp_pins(k - 10, live));
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL disable k=%0d got=%h exp=%h", k, got_v, exp_v); end
    end
  endtask

  task automatic test_reset_in_gap();
    logic [12:0] got_v, exp_v;
    logic        pend_exp;
    do_reset();
    for (int k = 0; k <= 48; k++) begin
      drive_idle();
      i_en  = (k < 5) || (k >= 8);
      i_rst = (k == 5);
      if (k == 0) drive_wr(3'd0, 5'h09);
      if (k == 2 || k == 10) i_commit = 1'b1;
      if (k < 5)       exp_q.push_back(exp_pins(k, 20'd0));
      else if (k < 8)  exp_q.push_back(DARK);
      else             exp_q.push_back(exp_pins(k - 8, 20'd0));
      pend_exp = ((k >= 2) && (k < 5)) || ((k >= 10) && (k < 28));
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL rst_gap k=%0d got=%h exp=%h", k, got_v, exp_v); end
      n_checks++;
      if (o_commit_pend !== pend_exp) begin n_errors++; $display("FAIL rst_gap_pend k=%0d got=%b exp=%b", k, o_commit_pend, pend_exp); end
    end
    i_rst = 1'b0;
  endtask

  task automatic test_leading_zero();
    logic [12:0] got_v, exp_v;
    logic [19:0] live;
    int lit3 = 0;
    int lit3_exp;
    live = {5'h00, 5'h03, 5'h00, 5'h00};
`ifdef LEADING_ZERO_BLANK_EN
    lit3_exp = 0;
`else
    lit3_exp = 8;
`endif
    do_reset();
    for (int j = 0; j < 3; j++) begin
      drive_idle();
      if (j == 0) drive_wr(3'd2, 5'h03);
      if (j == 1) i_commit = 1'b1;
      tick();
    end
    for (int k = 0; k <= 40; k++) begin
      drive_idle();
      i_en = 1'b1;
      exp_q.push_back(exp_pins(k, live));
      tick();
      got_v = {o_frame_done, o_dig_sel, o_seg};
      exp_v = exp_q.pop_front();
      if (o_dig_sel[3] === 1'b0) lit3++;
      n_checks++;
      if (got_v !== exp_v) begin n_errors++; $display("FAIL lzb k=%0d got=%h exp=%h", k, got_v, exp_v); end
    end
    n_checks++;
    if (lit3 !== lit3_exp) begin n_errors++; $display("FAIL lzb_digit3_lit got=%0d exp=%0d", lit3, lit3_exp); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_commit();
    test_write_no_commit();
    test_back_to_back();
    test_disable();
    test_reset_in_gap();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
